// File: rtl/intr_pkg.sv
// Shared constants and types for the interrupt source conditioner.
// The INTR_DEBOUNCE_EN build option only affects intr_line_cond.
package intr_pkg;

    localparam int PERIPHERALS     = 16;
    localparam int IDX_W           = $clog2(PERIPHERALS);
    localparam int ADDR_W          = 3;
    localparam int DEBOUNCE_CYCLES = 4;

    typedef enum logic [ADDR_W-1:0] {
        REG_MODE = 3'd0,
        REG_POL  = 3'd1,
        REG_EN   = 3'd2,
        REG_PEND = 3'd3
    } reg_addr_e;

    typedef logic [PERIPHERALS-1:0] line_vec_t;

endpackage

// File: rtl/intr_source_cond_if.sv
// Configuration access bus of the interrupt source conditioner.
interface intr_source_cond_if;
    import intr_pkg::*;

    logic              wr_rd;
    logic              enable;
    logic [ADDR_W-1:0] addr;
    line_vec_t         wdata;
    line_vec_t         rdata;
    logic              ready;
    logic              error;

    modport master (output wr_rd, enable, addr, wdata, input rdata, ready, error);
    modport slave  (input wr_rd, enable, addr, wdata, output rdata, ready, error);

endinterface

// File: rtl/intr_line_cond.sv
// One interrupt line: synchroniser, optional debounce (INTR_DEBOUNCE_EN),
// polarity and edge detection against a history flop.
module intr_line_cond
    import intr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic irq_raw,
    input  logic pol,
    input  logic warming,
    output logic cond,
    output logic edge_pulse
);

    logic sync1_r;
    logic sync2_r;
    logic level_s;
    logic hist_r;

    // two-flop synchroniser for the asynchronous request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= irq_raw;
            sync2_r <= sync1_r;
        end
    end

`ifdef INTR_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             filt_r;

    // debounce: flip only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            filt_r <= 1'b0;
        end else if (warming) begin
            filt_r <= sync1_r;
            cnt_r  <= '0;
        end else if (sync2_r == filt_r) begin
            cnt_r  <= '0;
        end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_r <= sync2_r;
            cnt_r  <= '0;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
        end
    end

    assign level_s = filt_r;
`else
    assign level_s = sync2_r;
`endif

    // History holds the pre-polarity level, so a POL change flips both sides of
    // the compare together. During warm-up it preloads the level's next value so
    // lines already active at reset release never look like a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_r <= 1'b0;
        end else if (warming) begin
            hist_r <= sync1_r;
        end else begin
            hist_r <= level_s;
        end
    end

    assign cond       = level_s ^ pol;
    assign edge_pulse = cond & ~(hist_r ^ pol) & ~warming;

endmodule

// File: rtl/intr_source_cond.sv
// Interrupt source conditioner: register file, pending latch, warm-up and access handshake.
// Build option INTR_DEBOUNCE_EN adds a per-line debounce filter inside intr_line_cond.
module intr_source_cond
    import intr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  line_vec_t          irq_raw,
    intr_source_cond_if.slave  cfg,
    input  logic               intr_service,
    input  logic [IDX_W-1:0]   intr_to_serv,
    output line_vec_t          intr_active
);

    line_vec_t mode_r, pol_r, en_r, pend_r;
    line_vec_t mode_next_s, pol_next_s, en_next_s, pend_next_s;
    line_vec_t pend_wclr_s, serv_clr_s, active_next_s;
    line_vec_t cond_s, edge_s;
    line_vec_t rd_data_s, rdata_r, intr_active_r;
    logic      ready_r, error_r;
    logic      access_s, addr_ok_s, warming_s;
    logic [1:0] warm_r;

    assign warming_s = (warm_r != 2'd2);

    for (genvar gi = 0; gi < PERIPHERALS; gi++) begin : g_line
        intr_line_cond u_line (
            .clk        (clk),
            .rst        (rst),
            .irq_raw    (irq_raw[gi]),
            .pol        (pol_r[gi]),
            .warming    (warming_s),
            .cond       (cond_s[gi]),
            .edge_pulse (edge_s[gi])
        );
    end

    // a new request while the previous one is still completing is dropped
    assign access_s = cfg.enable & ~ready_r;

    // register decode: next config values, PEND write-1-to-clear mask and read data
    always_comb begin
        mode_next_s = mode_r;
        pol_next_s  = pol_r;
        en_next_s   = en_r;
        pend_wclr_s = '0;
        rd_data_s   = '0;
        addr_ok_s   = 1'b0;
        if (access_s) begin
            case (cfg.addr)
                REG_MODE: begin
                    addr_ok_s = 1'b1;
                    if (cfg.wr_rd) mode_next_s = cfg.wdata;
                    else           rd_data_s   = mode_r;
                end
                REG_POL: begin
                    addr_ok_s = 1'b1;
                    if (cfg.wr_rd) pol_next_s = cfg.wdata;
                    else           rd_data_s  = pol_r;
                end
                REG_EN: begin
                    addr_ok_s = 1'b1;
                    if (cfg.wr_rd) en_next_s = cfg.wdata;
                    else           rd_data_s = en_r;
                end
                REG_PEND: begin
                    addr_ok_s = 1'b1;
                    if (cfg.wr_rd) pend_wclr_s = cfg.wdata;
                    else           rd_data_s   = pend_r;
                end
                default: addr_ok_s = 1'b0;
            endcase
        end else begin
            addr_ok_s = 1'b0;
        end
    end

    // pending latch: set beats clear, level-mode lines hold PEND at zero
    always_comb begin
        serv_clr_s = '0;
        for (int i = 0; i < PERIPHERALS; i++) begin
            serv_clr_s[i] = intr_service && (intr_to_serv == IDX_W'(i));
        end
        pend_next_s   = mode_next_s & (edge_s | (pend_r & ~serv_clr_s & ~pend_wclr_s));
        active_next_s = en_next_s & ((mode_next_s & pend_next_s) | (~mode_next_s & cond_s));
    end

    // config, pending and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r        <= '0;
            pol_r         <= '0;
            en_r          <= '0;
            pend_r        <= '0;
            ready_r       <= 1'b0;
            error_r       <= 1'b0;
            rdata_r       <= '0;
            intr_active_r <= '0;
        end else begin
            mode_r        <= mode_next_s;
            pol_r         <= pol_next_s;
            en_r          <= en_next_s;
            pend_r        <= pend_next_s;
            ready_r       <= access_s;
            error_r       <= access_s & ~addr_ok_s;
            rdata_r       <= rd_data_s;
            intr_active_r <= active_next_s;
        end
    end

    // warm-up counter: edge detection blocked for the first two cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_r <= 2'd0;
        end else if (warming_s) begin
            warm_r <= warm_r + 2'd1;
        end else begin
            warm_r <= warm_r;
        end
    end

    assign cfg.rdata   = rdata_r;
    assign cfg.ready   = ready_r;
    assign cfg.error   = error_r;
    assign intr_active = intr_active_r;

endmodule

// File: tb/tb_intr_source_cond.sv
// Directed, table-driven bench for intr_source_cond.
module tb_intr_source_cond;
    import intr_pkg::*;

`ifdef INTR_DEBOUNCE_EN
    localparam int LAT = 3 + DEBOUNCE_CYCLES;
    localparam int PW  = DEBOUNCE_CYCLES;
`else
    localparam int LAT = 3;
    localparam int PW  = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    line_vec_t        irq_raw = '0;
    logic             intr_service = 1'b0;
    logic [IDX_W-1:0] intr_to_serv = '0;
    line_vec_t        intr_active;

    int n_checks = 0;
    int n_fail   = 0;

    intr_source_cond_if bus ();

    intr_source_cond dut (
        .clk          (clk),
        .rst          (rst),
        .irq_raw      (irq_raw),
        .cfg          (bus.slave),
        .intr_service (intr_service),
        .intr_to_serv (intr_to_serv),
        .intr_active  (intr_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_error;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cfg_do(input logic wr, input logic [2:0] a, input logic [15:0] wd,
                          input logic [15:0] exp_rd, input logic exp_err, input string name);
        bus.wr_rd  = wr;
        bus.addr   = a;
        bus.wdata  = wd;
        bus.enable = 1'b1;
        tick();
        check({name, "_ready"}, 32'(bus.ready), 32'd1);
        check({name, "_rdata"}, 32'(bus.rdata), 32'(exp_rd));
        check({name, "_error"}, 32'(bus.error), 32'(exp_err));
        bus.enable = 1'b0;
        tick();
        check({name, "_ready_drop"}, 32'(bus.ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 3'd1, 16'h0000, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 3'd2, 16'h0000, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 3'd5, 16'h0000, 16'h0000, 1'b1};
        vecs[5]  = '{1'b1, 3'd6, 16'hFFFF, 16'h0000, 1'b1};
        vecs[6]  = '{1'b0, 3'd4, 16'h0000, 16'h0000, 1'b1};
        vecs[7]  = '{1'b1, 3'd0, 16'h00A5, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 16'h0000, 16'h00A5, 1'b0};
        vecs[9]  = '{1'b1, 3'd2, 16'h1234, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 3'd2, 16'h0000, 16'h1234, 1'b0};
        vecs[11] = '{1'b1, 3'd7, 16'hFFFF, 16'h0000, 1'b1};
        vecs[12] = '{1'b0, 3'd0, 16'h0000, 16'h00A5, 1'b0};
        vecs[13] = '{1'b1, 3'd3, 16'hFFFF, 16'h0000, 1'b0};
        vecs[14] = '{1'b1, 3'd0, 16'h0000, 16'h0000, 1'b0};
        vecs[15] = '{1'b1, 3'd2, 16'h0000, 16'h0000, 1'b0};

        bus.wr_rd = 1'b0; bus.addr = '0; bus.wdata = '0; bus.enable = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_active", 32'(intr_active), 32'd0);
        check("rst_ready",  32'(bus.ready),   32'd0);
        check("rst_rdata",  32'(bus.rdata),   32'd0);
        check("rst_error",  32'(bus.error),   32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // register access table
        for (int i = 0; i < 16; i++) begin
            cfg_do(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                   vecs[i].exp_error, $sformatf("vec%0d", i));
        end

        // enable held while ready=1 is ignored
        bus.wr_rd = 1'b0; bus.addr = 3'd0; bus.enable = 1'b1;
        tick();
        check("hold_ready1", 32'(bus.ready), 32'd1);
        bus.wr_rd = 1'b1; bus.wdata = 16'hFFFF;
        tick();
        check("hold_ready2", 32'(bus.ready), 32'd0);
        bus.enable = 1'b0;
        tick();
        cfg_do(1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, "hold_mode");

        // level mode, line 0
        cfg_do(1'b1, 3'd2, 16'h0001, 16'h0000, 1'b0, "lvl_en");
        irq_raw[0] = 1'b1;
        repeat (LAT - 1) tick();
        check("lvl_rise_early", 32'(intr_active), 32'd0);
        tick();
        check("lvl_rise", 32'(intr_active), 32'h0001);
        repeat (10 - LAT) tick();
        check("lvl_hold", 32'(intr_active), 32'h0001);
        irq_raw[0] = 1'b0;
        repeat (LAT - 1) tick();
        check("lvl_fall_early", 32'(intr_active), 32'h0001);
        tick();
        check("lvl_fall", 32'(intr_active), 32'd0);
        cfg_do(1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0, "lvl_pend");

        // edge mode, line 3: latch, service, EN gating, W1C, mode change
        cfg_do(1'b1, 3'd0, 16'h0008, 16'h0000, 1'b0, "e3_mode");
        cfg_do(1'b1, 3'd2, 16'h0008, 16'h0000, 1'b0, "e3_en");
        irq_raw[3] = 1'b1;
        repeat (PW) tick();
        irq_raw[3] = 1'b0;
        repeat (LAT) tick();
        check("e3_active", 32'(intr_active), 32'h0008);
        cfg_do(1'b0, 3'd3, 16'h0000, 16'h0008, 1'b0, "e3_pend");
        intr_service = 1'b1; intr_to_serv = 4'd4;
        tick();
        intr_service = 1'b0;
        check("e3_wrong_serv", 32'(intr_active), 32'h0008);
        intr_service = 1'b1; intr_to_serv = 4'd3;
        tick();
        intr_service = 1'b0;
        check("e3_served", 32'(intr_active), 32'd0);
        cfg_do(1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0, "e3_pend_clr");
        cfg_do(1'b1, 3'd2, 16'h0000, 16'h0000, 1'b0, "e3_en_off");
        irq_raw[3] = 1'b1;
        repeat (PW) tick();
        irq_raw[3] = 1'b0;
        repeat (LAT) tick();
        check("e3_masked", 32'(intr_active), 32'd0);
        cfg_do(1'b0, 3'd3, 16'h0000, 16'h0008, 1'b0, "e3_pend_masked");
        cfg_do(1'b1, 3'd2, 16'h0008, 16'h0000, 1'b0, "e3_en_on");
        check("e3_unmasked", 32'(intr_active), 32'h0008);
        cfg_do(1'b1, 3'd3, 16'h0008, 16'h0000, 1'b0, "e3_w1c");
        check("e3_w1c_active", 32'(intr_active), 32'd0);
        irq_raw[3] = 1'b1;
        repeat (PW) tick();
        irq_raw[3] = 1'b0;
        repeat (LAT) tick();
        cfg_do(1'b0, 3'd3, 16'h0000, 16'h0008, 1'b0, "e3_pend_again");
        cfg_do(1'b1, 3'd0, 16'h0000, 16'h0000, 1'b0, "e3_to_level");
        cfg_do(1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0, "e3_pend_lvl");

        // edge mode, line 5: new edge and W1C in the same cycle
        cfg_do(1'b1, 3'd0, 16'h0020, 16'h0000, 1'b0, "e5_mode");
        cfg_do(1'b1, 3'd2, 16'h0020, 16'h0000, 1'b0, "e5_en");
        irq_raw[5] = 1'b1;
        repeat (LAT - 1) tick();
        cfg_do(1'b1, 3'd3, 16'h0020, 16'h0000, 1'b0, "e5_w1c");
        cfg_do(1'b0, 3'd3, 16'h0000, 16'h0020, 1'b0, "e5_set_wins");
        check("e5_active", 32'(intr_active), 32'h0020);

        // reset mid-operation drops ready and pending, then warm-up with POL
        irq_raw[2] = 1'b1;
        bus.wr_rd = 1'b0; bus.addr = 3'd0; bus.enable = 1'b1;
        tick();
        check("mid_ready", 32'(bus.ready), 32'd1);
        rst = 1'b1;
        #1;
        bus.enable = 1'b0;
        check("mid_ready_drop", 32'(bus.ready), 32'd0);
        check("mid_active", 32'(intr_active), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        cfg_do(1'b1, 3'd0, 16'h0084, 16'h0000, 1'b0, "w_mode");
        cfg_do(1'b1, 3'd1, 16'h0080, 16'h0000, 1'b0, "w_pol");
        cfg_do(1'b1, 3'd2, 16'h0084, 16'h0000, 1'b0, "w_en");
        cfg_do(1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0, "w_pend");
        check("w_active", 32'(intr_active), 32'd0);
        irq_raw[7] = 1'b1;
        repeat (8) tick();
        check("w_pol_rise", 32'(intr_active), 32'd0);
        irq_raw[7] = 1'b0;
        repeat (LAT + 2) tick();
        check("w_pol_fall", 32'(intr_active), 32'h0080);
        cfg_do(1'b0, 3'd3, 16'h0000, 16'h0080, 1'b0, "w_pend7");

`ifdef INTR_DEBOUNCE_EN
        // debounce: short pulse dropped, full pulse latched, reset mid-count
        cfg_do(1'b1, 3'd0, 16'h0200, 16'h0000, 1'b0, "db_mode");
        cfg_do(1'b1, 3'd2, 16'h0200, 16'h0000, 1'b0, "db_en");
        irq_raw[9] = 1'b1;
        repeat (DEBOUNCE_CYCLES - 1) tick();
        irq_raw[9] = 1'b0;
        repeat (12) tick();
        cfg_do(1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0, "db_short");
        irq_raw[9] = 1'b1;
        repeat (DEBOUNCE_CYCLES) tick();
        irq_raw[9] = 1'b0;
        repeat (12) tick();
        cfg_do(1'b0, 3'd3, 16'h0000, 16'h0200, 1'b0, "db_full");
        irq_raw[9] = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("db_rst_active", 32'(intr_active), 32'd0);
        irq_raw[9] = 1'b0;
        rst = 1'b0;
        repeat (12) tick();
        cfg_do(1'b0, 3'd3, 16'h0000, 16'h0000, 1'b0, "db_rst_pend");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
